alu_vec_sequencer: RTL and testbench
====================================

ALU_VEC_SEQUENCER -- requirements
Module: alu_vec_sequencer

Interface
REQ-001 Parameters SHALL be, one per line:
- WIDTH, 4, lane operand width in bits.
- N_LANE, 4, number of lanes per vector operation.
- ALU_LAT, 1, shared-ALU result latency in cycles (legal range 1..4).
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all logic on rising edge.
- arst  in  1  reset, synchronous, active-high.
- req_valid  in  1  vector request valid.
- req_ready  out  1  sequencer can accept a request.
- req_a  in  WIDTH*N_LANE  packed operand A; lane k = bits [k*WIDTH +: WIDTH].
- req_b  in  WIDTH*N_LANE  packed operand B; same packing.
- req_select  in  3  ALU opcode for the whole vector.
- alu_en  out  1  lane issue strobe to the shared ALU.
- alu_a  out  WIDTH  lane operand A to the ALU.
- alu_b  out  WIDTH  lane operand B to the ALU.
- alu_select  out  3  opcode to the ALU.
- alu_out  in  8  ALU lane result, valid ALU_LAT cycles after issue.
- alu_carry_out  in  1  ALU carry, valid with alu_out.
- res_valid  out  1  result vector valid.
- res_ready  in  1  consumer accepts the result.
- res_data  out  8*N_LANE  packed results; lane k = bits [k*8 +: 8].
- res_carry  out  N_LANE  per-lane carry.
- busy  out  1  high whenever the state is not IDLE.

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, DRAIN and DONE.
REQ-004 req_ready SHALL be 1 only in IDLE; a handshake occurs when req_valid && req_ready.
REQ-005 On handshake, the block SHALL latch req_a, req_b and req_select, clear res_data and res_carry, and go IDLE->ISSUE.
REQ-006 ISSUE SHALL last exactly N_LANE cycles.
- In issue cycle k: alu_en=1, alu_a = lane k of the latched A, alu_b = lane k of the latched B.
- Lanes issue in order 0..N_LANE-1, one per cycle, with no bubbles.
REQ-007 alu_select SHALL equal the latched opcode from ISSUE through DRAIN, and 0 otherwise.
REQ-008 Outside ISSUE, alu_en, alu_a and alu_b SHALL be 0.
REQ-009 Capture tracking SHALL use an ALU_LAT-deep shift register of {valid, lane index}; each issued lane is captured exactly ALU_LAT cycles after issue.
REQ-010 On capture of lane k, alu_out SHALL be written to res_data[k*8 +: 8] and alu_carry_out to res_carry[k]; other lanes are unchanged.
REQ-011 After the last issue, the FSM SHALL go ISSUE->DRAIN; DRAIN->DONE occurs in the cycle lane N_LANE-1 is captured.
REQ-012 In DONE, res_valid SHALL be 1, and res_data/res_carry SHALL be held stable until res_valid && res_ready.
REQ-013 On res_valid && res_ready, the FSM SHALL go DONE->IDLE.
- req_ready rises the following cycle; there is no same-cycle back-to-back acceptance.
REQ-014 Latency SHALL be fixed: handshake at cycle T gives res_valid first high at cycle T+N_LANE+ALU_LAT+1, independent of the data.
REQ-015 Counters SHALL be sized to clog2(N_LANE) bits minimum; the issue counter does not wrap within an operation.
REQ-016 req_* inputs SHALL be ignored outside IDLE; changes to them during an operation have no effect.
REQ-017 res_ready asserted outside DONE SHALL have no effect.
REQ-018 busy SHALL equal (state != IDLE).

Reset
REQ-019 While arst=1 at a rising edge, the block SHALL enter IDLE and clear latched operands, res_data, res_carry and the capture pipeline.
REQ-020 Output values while in reset SHALL be: req_ready=1, busy=0, res_valid=0, alu_en=0, alu_a=0, alu_b=0, alu_select=0, res_data=0, res_carry=0.
REQ-021 Reset mid-operation (ISSUE, DRAIN or DONE) SHALL abort the operation.
- No res_valid pulse for it; in-flight captures are discarded.
- A request is accepted in the first cycle after arst deasserts.

Verification
REQ-022 The bench SHALL model the ALU as a registered 8-bit adder {carry, sum} with ALU_LAT=1, and use WIDTH=4, N_LANE=4 unless stated otherwise.
REQ-023 Scenarios the bench SHALL cover:
- Basic add: req_a=16'h4321, req_b=16'h1111, select=0 -> res_data=32'h05040302, res_carry=4'b0000, res_valid at T+6.
- Carry: req_a=16'hFFFF, req_b=16'h0001, select=0 -> lane0 alu_out=8'h10, res_carry=4'b0001, lanes 1-3 = 8'h0F.
- Backpressure: hold res_ready=0 for 10 cycles in DONE -> res_valid stays 1, res_data stable, req_ready=0 throughout; IDLE the cycle after res_ready=1.
- Issue order: check alu_en=1 for exactly 4 consecutive cycles, alu_a sequence 1,2,3,4 for req_a=16'h4321, alu_select constant.
- Reset mid-op: assert arst during DRAIN -> res_valid never rises for that request; next request returns the correct result.
- ALU_LAT=3: same as the basic add -> identical res_data, res_valid at T+8.

Source files
------------

// File: rtl/alu_vec_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_vec_sequencer_if
//   Bundles every non-clock/reset signal of alu_vec_sequencer.
//   - request side : req_valid/req_ready handshake carrying req_a, req_b and
//                    req_select (lane k of an operand = bits [k*WIDTH +: WIDTH])
//   - ALU side     : alu_en/alu_a/alu_b/alu_select out, alu_out/alu_carry_out in
//   - result side  : res_valid/res_ready handshake carrying res_data
//                    (lane k = bits [k*8 +: 8]) and res_carry (one bit per lane)
//   - status       : busy, dbg_state (raw FSM state encoding)
//   modport slave  : the sequencer's view
//   modport master : the environment's view (requester, ALU and consumer)
// ---------------------------------------------------------------------------
interface alu_vec_sequencer_if #(
    parameter int WIDTH  = 4,
    parameter int N_LANE = 4
);
    logic                      req_valid;
    logic                      req_ready;
    logic [WIDTH*N_LANE-1:0]   req_a;
    logic [WIDTH*N_LANE-1:0]   req_b;
    logic [2:0]                req_select;

    logic                      alu_en;
    logic [WIDTH-1:0]          alu_a;
    logic [WIDTH-1:0]          alu_b;
    logic [2:0]                alu_select;
    logic [7:0]                alu_out;
    logic                      alu_carry_out;

    logic                      res_valid;
    logic                      res_ready;
    logic [8*N_LANE-1:0]       res_data;
    logic [N_LANE-1:0]         res_carry;

    logic                      busy;
    logic [1:0]                dbg_state;

    modport slave (
        input  req_valid, req_a, req_b, req_select,
        input  alu_out, alu_carry_out,
        input  res_ready,
        output req_ready,
        output alu_en, alu_a, alu_b, alu_select,
        output res_valid, res_data, res_carry,
        output busy, dbg_state
    );

    modport master (
        output req_valid, req_a, req_b, req_select,
        output alu_out, alu_carry_out,
        output res_ready,
        input  req_ready,
        input  alu_en, alu_a, alu_b, alu_select,
        input  res_valid, res_data, res_carry,
        input  busy, dbg_state
    );
endinterface

// File: rtl/alu_vec_sequencer.sv
// ---------------------------------------------------------------------------
// alu_vec_sequencer
//   Accepts one vector request (N_LANE lanes of WIDTH-bit operands plus one
//   opcode), issues the lanes one per cycle to a shared pipelined ALU with a
//   fixed result latency of ALU_LAT cycles, gathers the 8-bit lane results and
//   per-lane carries, and presents the assembled vector on the result port.
//
// Ports
//   clk   : rising-edge clock
//   arst  : synchronous active-high reset (aborts any operation in flight)
//   bus   : alu_vec_sequencer_if.slave (request, ALU, result, status signals)
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The request side is ready only in IDLE; the result side holds
// res_valid and its payload stable in DONE until res_ready is seen. Neither
// valid depends combinationally on the corresponding ready.
//
// Latency is data independent: a request accepted in cycle T produces
// res_valid first in cycle T + N_LANE + ALU_LAT + 1.
// ---------------------------------------------------------------------------
module alu_vec_sequencer #(
    parameter int WIDTH   = 4,
    parameter int N_LANE  = 4,
    parameter int ALU_LAT = 1
) (
    input  logic               clk,
    input  logic               arst,
    alu_vec_sequencer_if.slave bus
);

    localparam int CW = (N_LANE > 1) ? $clog2(N_LANE) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(N_LANE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [WIDTH*N_LANE-1:0]      a_q, a_d;
    logic [WIDTH*N_LANE-1:0]      b_q, b_d;
    logic [2:0]                   op_q, op_d;
    logic [8*N_LANE-1:0]          data_q, data_d;
    logic [N_LANE-1:0]            carry_q, carry_d;

    // Capture tracker: entry ALU_LAT-1 names the lane whose result is on
    // alu_out in the current cycle.
    logic [ALU_LAT-1:0]           pipe_vld_q, pipe_vld_d;
    logic [ALU_LAT-1:0][CW-1:0]   pipe_idx_q, pipe_idx_d;

    logic                         issuing;
    logic                         cap_vld;
    logic [CW-1:0]                cap_idx;
    logic [WIDTH-1:0]             lane_a;
    logic [WIDTH-1:0]             lane_b;

    assign issuing = (state_q == ISSUE);
    assign cap_vld = pipe_vld_q[ALU_LAT-1];
    assign cap_idx = pipe_idx_q[ALU_LAT-1];

    // Lane operand selection; forced to zero outside ISSUE.
    always_comb begin
        lane_a = '0;
        lane_b = '0;
        if (issuing) begin
            for (int k = 0; k < N_LANE; k++) begin
                if (cnt_q == CW'(k)) begin
                    lane_a = a_q[k*WIDTH +: WIDTH];
                    lane_b = b_q[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        data_d     = data_q;
        carry_d    = carry_q;
        pipe_vld_d = '0;
        pipe_idx_d = '0;

        pipe_vld_d[0] = issuing;
        pipe_idx_d[0] = cnt_q;
        for (int i = 1; i < ALU_LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_idx_d[i] = pipe_idx_q[i-1];
        end

        // Write the returning lane into its slot; other lanes keep their value.
        if (cap_vld) begin
            for (int k = 0; k < N_LANE; k++) begin
                if (cap_idx == CW'(k)) begin
                    data_d[k*8 +: 8] = bus.alu_out;
                    carry_d[k]       = bus.alu_carry_out;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    op_d    = bus.req_select;
                    data_d  = '0;
                    carry_d = '0;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // The counter stops at the last lane instead of wrapping.
                if (cnt_q == LAST_LANE) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DRAIN: begin
                if (cap_vld && (cap_idx == LAST_LANE)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            data_q     <= '0;
            carry_q    <= '0;
            pipe_vld_q <= '0;
            pipe_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            data_q     <= data_d;
            carry_q    <= carry_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_idx_q <= pipe_idx_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.res_valid  = (state_q == DONE);
    assign bus.res_data   = data_q;
    assign bus.res_carry  = carry_q;
    assign bus.alu_en     = issuing;
    assign bus.alu_a      = lane_a;
    assign bus.alu_b      = lane_b;
    assign bus.alu_select = ((state_q == ISSUE) || (state_q == DRAIN)) ? op_q : 3'd0;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_alu_vec_sequencer.sv
module tb_alu_vec_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_err = 0;

  alu_vec_sequencer_if #(.WIDTH(4), .N_LANE(4)) if1 ();
  alu_vec_sequencer_if #(.WIDTH(4), .N_LANE(4)) if3 ();

  alu_vec_sequencer #(.WIDTH(4), .N_LANE(4), .ALU_LAT(1)) dut1 (
    .clk (clk),
    .arst(arst),
    .bus (if1.slave)
  );

  alu_vec_sequencer #(.WIDTH(4), .N_LANE(4), .ALU_LAT(3)) dut3 (
    .clk (clk),
    .arst(arst),
    .bus (if3.slave)
  );

  // ---------------- ALU models: registered adder {carry, sum} ----------------
  logic [7:0] sum1, sum3;
  assign sum1 = {4'b0, if1.alu_a} + {4'b0, if1.alu_b};
  assign sum3 = {4'b0, if3.alu_a} + {4'b0, if3.alu_b};

  always @(posedge clk) begin
    if1.alu_out       <= sum1;
    if1.alu_carry_out <= sum1[4];
  end

  logic [7:0] s3_0, s3_1;
  always @(posedge clk) begin
    s3_0              <= sum3;
    s3_1              <= s3_0;
    if3.alu_out       <= s3_1;
    if3.alu_carry_out <= s3_1[4];
  end

  // ---------------- issue monitor (dut1) ----------------
  logic [3:0] log_a[$];
  logic [3:0] log_b[$];
  logic [2:0] log_sel[$];
  int         log_cyc[$];
  always @(negedge clk) begin
    if (if1.alu_en) begin
      log_a.push_back(if1.alu_a);
      log_b.push_back(if1.alu_b);
      log_sel.push_back(if1.alu_select);
      log_cyc.push_back(cyc);
    end
  end

  // ---------------- scoreboard ----------------
  logic [35:0] exp_q[$];
  logic [35:0] last_res;

  function automatic logic [35:0] model(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] d;
    logic [3:0]  c;
    logic [7:0]  s;
    d = '0;
    c = '0;
    for (int k = 0; k < 4; k++) begin
      s = {4'b0, a[k*4 +: 4]} + {4'b0, b[k*4 +: 4]};
      d[k*8 +: 8] = s;
      c[k] = s[4];
    end
    return {c, d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic op1(input logic [15:0] a, input logic [15:0] b, input logic [2:0] sel,
                     input int hold, input string name);
    int g;
    logic [35:0] exp, got, first;
    @(negedge clk);
    if1.req_a = a; if1.req_b = b; if1.req_select = sel; if1.req_valid = 1'b1;
    g = 0;
    while (!if1.req_ready && g < 50) begin @(negedge clk); g++; end
    n_vec++;
    if (if1.req_ready !== 1'b1) begin
      n_err++; $display("FAIL %s_accept: req_ready=%b required 1", name, if1.req_ready);
    end
    exp_q.push_back(model(a, b));
    @(negedge clk);
    // Inputs change freely during the operation and must be ignored.
    if1.req_valid = 1'b0;
    if1.req_a = 16'($urandom_range(0, 65535));
    if1.req_b = 16'($urandom_range(0, 65535));
    if1.req_select = 3'($urandom_range(0, 7));
    g = 1;
    while (!if1.res_valid && g < 50) begin @(negedge clk); g++; end
    n_vec++;
    if (g !== 6) begin
      n_err++; $display("FAIL %s_latency: res_valid after %0d cycles required 6", name, g);
    end
    n_vec++;
    if (if1.req_ready !== 1'b0) begin
      n_err++; $display("FAIL %s_ready_in_done: req_ready=%b required 0", name, if1.req_ready);
    end
    first = {if1.res_carry, if1.res_data};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_vec++;
      if ({if1.res_valid, if1.req_ready, if1.res_carry, if1.res_data} !== {1'b1, 1'b0, first}) begin
        n_err++;
        $display("FAIL %s_hold%0d: valid=%b ready=%b res=%h required valid=1 ready=0 res=%h",
                 name, i, if1.res_valid, if1.req_ready, {if1.res_carry, if1.res_data}, first);
      end
    end
    if1.res_ready = 1'b1;
    exp = exp_q.pop_front();
    got = {if1.res_carry, if1.res_data};
    last_res = got;
    n_vec++;
    if (got !== exp) begin
      n_err++; $display("FAIL %s_result: {carry,data}=%h required %h", name, got, exp);
    end
    @(negedge clk);
    if1.res_ready = 1'b0;
    n_vec++;
    if ({if1.busy, if1.req_ready, if1.res_valid} !== 3'b010) begin
      n_err++;
      $display("FAIL %s_idle: busy/ready/valid=%b required 010",
               name, {if1.busy, if1.req_ready, if1.res_valid});
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    arst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({if1.req_ready, if1.busy, if1.res_valid, if1.alu_en, if1.alu_a, if1.alu_b,
         if1.alu_select, if1.res_carry, if1.res_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0, 4'h0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_dut1: ready=%b busy=%b valid=%b en=%b a=%h b=%h sel=%h c=%h d=%h required 1 0 0 0 0 0 0 0 0",
               if1.req_ready, if1.busy, if1.res_valid, if1.alu_en, if1.alu_a, if1.alu_b,
               if1.alu_select, if1.res_carry, if1.res_data);
    end
    n_vec++;
    if ({if3.req_ready, if3.busy, if3.res_valid, if3.alu_en, if3.alu_a, if3.alu_b,
         if3.alu_select, if3.res_carry, if3.res_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0, 4'h0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_dut3: ready=%b busy=%b valid=%b c=%h d=%h required 1 0 0 0 0",
               if3.req_ready, if3.busy, if3.res_valid, if3.res_carry, if3.res_data);
    end
    arst = 1'b0;
  endtask

  task automatic test_basic_add();
    op1(16'h4321, 16'h1111, 3'd0, 0, "basic");
    n_vec++;
    if (last_res !== {4'b0000, 32'h05040302}) begin
      n_err++; $display("FAIL basic_const: {carry,data}=%h required 005040302", last_res);
    end
  endtask

  task automatic test_carry();
    op1(16'hFFFF, 16'h0001, 3'd0, 0, "carry");
    n_vec++;
    if (last_res !== {4'b0001, 32'h0F0F0F10}) begin
      n_err++; $display("FAIL carry_const: {carry,data}=%h required 10F0F0F10", last_res);
    end
  endtask

  task automatic test_backpressure();
    op1(16'h9A5C, 16'h36E7, 3'd2, 10, "bp");
  endtask

  task automatic test_issue_order();
    log_a.delete(); log_b.delete(); log_sel.delete(); log_cyc.delete();
    op1(16'h4321, 16'h1111, 3'd5, 0, "order");
    n_vec++;
    if (log_a.size() !== 4) begin
      n_err++; $display("FAIL order_count: alu_en cycles=%0d required 4", log_a.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_vec++;
        if ({log_a[k], log_b[k], log_sel[k]} !== {4'(k + 1), 4'd1, 3'd5} || log_cyc[k] !== log_cyc[0] + k) begin
          n_err++;
          $display("FAIL order_lane%0d: a=%0d b=%0d sel=%0d cyc_off=%0d required a=%0d b=1 sel=5 cyc_off=%0d",
                   k, log_a[k], log_b[k], log_sel[k], log_cyc[k] - log_cyc[0], k + 1, k);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    op1(16'h0F0F, 16'hF0F0, 3'd1, 0, "b2b_0");
    op1(16'h8888, 16'h8888, 3'd1, 1, "b2b_1");
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      op1(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
          3'($urandom_range(0, 7)), $urandom_range(0, 3), "rand");
    end
  endtask

  task automatic test_reset_mid_op();
    int g;
    int seen;
    @(negedge clk);
    if1.req_a = 16'h4321; if1.req_b = 16'h1111; if1.req_select = 3'd0; if1.req_valid = 1'b1;
    g = 0;
    while (!if1.req_ready && g < 50) begin @(negedge clk); g++; end
    @(negedge clk);
    if1.req_valid = 1'b0;
    g = 0;
    while (if1.dbg_state !== 2'd2 && g < 50) begin @(negedge clk); g++; end
    n_vec++;
    if (if1.dbg_state !== 2'd2) begin
      n_err++; $display("FAIL rst_mid_drain: state=%0d required 2", if1.dbg_state);
    end
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    n_vec++;
    if ({if1.busy, if1.req_ready, if1.res_valid, if1.res_carry, if1.res_data} !== {3'b010, 36'h0}) begin
      n_err++;
      $display("FAIL rst_mid_state: busy=%b ready=%b valid=%b res=%h required 0 1 0 0",
               if1.busy, if1.req_ready, if1.res_valid, {if1.res_carry, if1.res_data});
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if1.res_valid) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++; $display("FAIL rst_mid_novalid: res_valid cycles=%0d required 0", seen);
    end
    op1(16'h4321, 16'h1111, 3'd0, 0, "after_rst");
  endtask

  task automatic test_lat3();
    int g;
    logic [35:0] exp, got;
    @(negedge clk);
    if3.req_a = 16'h4321; if3.req_b = 16'h1111; if3.req_select = 3'd0; if3.req_valid = 1'b1;
    g = 0;
    while (!if3.req_ready && g < 50) begin @(negedge clk); g++; end
    exp_q.push_back(model(16'h4321, 16'h1111));
    @(negedge clk);
    if3.req_valid = 1'b0;
    if3.req_a = 16'hABCD;
    g = 1;
    while (!if3.res_valid && g < 50) begin @(negedge clk); g++; end
    n_vec++;
    if (g !== 8) begin
      n_err++; $display("FAIL lat3_latency: res_valid after %0d cycles required 8", g);
    end
    if3.res_ready = 1'b1;
    exp = exp_q.pop_front();
    got = {if3.res_carry, if3.res_data};
    n_vec++;
    if (got !== exp || got !== {4'b0000, 32'h05040302}) begin
      n_err++; $display("FAIL lat3_result: {carry,data}=%h required %h", got, exp);
    end
    @(negedge clk);
    if3.res_ready = 1'b0;
    n_vec++;
    if ({if3.busy, if3.req_ready} !== 2'b01) begin
      n_err++; $display("FAIL lat3_idle: busy/ready=%b required 01", {if3.busy, if3.req_ready});
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    arst = 1'b1;
    if1.req_valid = 1'b0; if1.req_a = '0; if1.req_b = '0; if1.req_select = '0; if1.res_ready = 1'b0;
    if3.req_valid = 1'b0; if3.req_a = '0; if3.req_b = '0; if3.req_select = '0; if3.res_ready = 1'b0;
    test_reset();
    test_basic_add();
    test_carry();
    test_backpressure();
    test_issue_order();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    test_lat3();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
